// File: rtl/pipe_control.sv
// pipe_control: pipelined LEGv8 control. Decodes in ID, carries the bundle through ID/EX, EX/MEM
// and MEM/WB, stalls on hazards and flushes on a taken branch. Forwarding: PIPE_CONTROL_FWD_EN.
module pipe_control #(
  parameter int unsigned REGW = 5,
  parameter int unsigned ZREG = 31
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [10:0]     instruct,
  input  logic [REGW-1:0] id_rn,
  input  logic [REGW-1:0] id_rm,
  input  logic [REGW-1:0] id_rd,
  input  logic            br_taken,
  output logic            stall,
  output logic [2:0]      ex_ALUSrc,
  output logic [1:0]      ex_ALUOp,
  output logic            ex_SetFlags,
  output logic            ex_Branch,
  output logic            ex_UncondB,
  output logic            ex_B,
  output logic [1:0]      ex_fwd_a,
  output logic [1:0]      ex_fwd_b,
  output logic            mem_MemRead,
  output logic            mem_MemWrite,
  output logic            wb_RegWrite,
  output logic            wb_MemtoReg,
  output logic [REGW-1:0] wb_rd,
  output logic            id_illegal
);

  localparam logic [REGW-1:0] ZRegIdx = REGW'(ZREG);

  typedef enum logic [3:0] {
    OpNone, OpB, OpBLt, OpCbz, OpStur, OpLdur, OpAddi, OpShift, OpFlags, OpMul
  } op_e;

  typedef struct packed {
    logic [2:0]      alu_src;
    logic [1:0]      alu_op;
    logic            set_flags;
    logic            branch;
    logic            uncond_b;
    logic            b_lt;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            mem_to_reg;
    logic [REGW-1:0] rd;
  } idex_t;

  typedef struct packed {
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            mem_to_reg;
    logic [REGW-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic            reg_write;
    logic            mem_to_reg;
    logic [REGW-1:0] rd;
  } memwb_t;

  op_e             op_cls;
  idex_t           dec;
  logic            use_rn, use_rm, use_rt;
  logic            src1_v, src2_v;
  logic [REGW-1:0] src1, src2;
  logic            hit_ex, load_use, hazard;

  idex_t  idex_d, idex_q;
  exmem_t exmem_d, exmem_q;
  memwb_t memwb_d, memwb_q;

  // Opcode classification; anything outside these ranges is illegal.
  always_comb begin
    op_cls = OpNone;
    if (instruct >= 11'd160 && instruct <= 11'd191) begin
      op_cls = OpB;
    end else if (instruct >= 11'd672 && instruct <= 11'd679) begin
      op_cls = OpBLt;
    end else if (instruct >= 11'd1440 && instruct <= 11'd1447) begin
      op_cls = OpCbz;
    end else if (instruct == 11'd1984) begin
      op_cls = OpStur;
    end else if (instruct == 11'd1986) begin
      op_cls = OpLdur;
    end else if (instruct == 11'd1160 || instruct == 11'd1161) begin
      op_cls = OpAddi;
    end else if (instruct == 11'd1690 || instruct == 11'd1691) begin
      op_cls = OpShift;
    end else if (instruct == 11'd1368 || instruct == 11'd1880) begin
      op_cls = OpFlags;
    end else if (instruct == 11'd1240) begin
      op_cls = OpMul;
    end
  end

  always_comb begin
    dec    = '0;
    use_rn = 1'b0;
    use_rm = 1'b0;
    use_rt = 1'b0;
    unique case (op_cls)
      OpB: begin
        dec.branch   = 1'b1;
        dec.uncond_b = 1'b1;
        dec.alu_src  = 3'b001;
      end
      OpBLt: begin
        dec.branch = 1'b1;
        dec.b_lt   = 1'b1;
      end
      OpCbz: begin
        dec.branch = 1'b1;
        use_rt     = 1'b1;
      end
      OpStur: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 3'b100;
        dec.alu_op    = 2'b10;
        use_rn        = 1'b1;
        use_rt        = 1'b1;
      end
      OpLdur: begin
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_src    = 3'b100;
        dec.alu_op     = 2'b10;
        use_rn         = 1'b1;
      end
      OpAddi: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 3'b010;
        dec.alu_op    = 2'b10;
        use_rn        = 1'b1;
      end
      OpShift: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b10;
        use_rn        = 1'b1;
      end
      OpFlags: begin
        dec.reg_write = 1'b1;
        dec.set_flags = 1'b1;
        dec.alu_op    = 2'b10;
        use_rn        = 1'b1;
        use_rm        = 1'b1;
      end
      OpMul: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b11;
        use_rn        = 1'b1;
        use_rm        = 1'b1;
      end
      default: ;
    endcase
    if (!id_valid) begin
      dec    = '0;
      use_rn = 1'b0;
      use_rm = 1'b0;
      use_rt = 1'b0;
    end
    // XZR is never a real destination; rd is kept only for instructions that write.
    if (id_rd == ZRegIdx) dec.reg_write = 1'b0;
    dec.rd = dec.reg_write ? id_rd : '0;
  end

  assign id_illegal = id_valid && (op_cls == OpNone);

  assign src1   = id_rn;
  assign src2   = use_rm ? id_rm : id_rd;
  assign src1_v = use_rn && (src1 != ZRegIdx);
  assign src2_v = (use_rm || use_rt) && (src2 != ZRegIdx);

  assign hit_ex   = idex_q.reg_write &&
                    ((src1_v && (src1 == idex_q.rd)) || (src2_v && (src2 == idex_q.rd)));
  assign load_use = idex_q.mem_read && hit_ex;

`ifdef PIPE_CONTROL_FWD_EN
  assign hazard = load_use;
`else
  logic hit_mem;
  assign hit_mem = exmem_q.reg_write &&
                   ((src1_v && (src1 == exmem_q.rd)) || (src2_v && (src2 == exmem_q.rd)));
  assign hazard  = load_use || hit_ex || hit_mem;
`endif

  // A taken branch discards everything younger, so it also cancels any pending stall.
  assign stall = hazard && !br_taken;

  always_comb begin
    idex_d = (br_taken || stall) ? '0 : dec;

    exmem_d = '0;
    if (!br_taken) begin
      exmem_d.mem_read   = idex_q.mem_read;
      exmem_d.mem_write  = idex_q.mem_write;
      exmem_d.reg_write  = idex_q.reg_write;
      exmem_d.mem_to_reg = idex_q.mem_to_reg;
      exmem_d.rd         = idex_q.rd;
    end

    memwb_d.reg_write  = exmem_q.reg_write;
    memwb_d.mem_to_reg = exmem_q.mem_to_reg;
    memwb_d.rd         = exmem_q.rd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

`ifdef PIPE_CONTROL_FWD_EN
  logic            src1_v_q, src2_v_q;
  logic [REGW-1:0] src1_q, src2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src1_v_q <= 1'b0;
      src2_v_q <= 1'b0;
      src1_q   <= '0;
      src2_q   <= '0;
    end else if (br_taken || stall) begin
      src1_v_q <= 1'b0;
      src2_v_q <= 1'b0;
      src1_q   <= '0;
      src2_q   <= '0;
    end else begin
      src1_v_q <= src1_v;
      src2_v_q <= src2_v;
      src1_q   <= src1;
      src2_q   <= src2;
    end
  end

  // EX/MEM holds the younger result, so it wins when both stages match.
  always_comb begin
    ex_fwd_a = 2'b00;
    ex_fwd_b = 2'b00;
    if (src1_v_q && exmem_q.reg_write && (exmem_q.rd == src1_q)) begin
      ex_fwd_a = 2'b10;
    end else if (src1_v_q && memwb_q.reg_write && (memwb_q.rd == src1_q)) begin
      ex_fwd_a = 2'b01;
    end
    if (src2_v_q && exmem_q.reg_write && (exmem_q.rd == src2_q)) begin
      ex_fwd_b = 2'b10;
    end else if (src2_v_q && memwb_q.reg_write && (memwb_q.rd == src2_q)) begin
      ex_fwd_b = 2'b01;
    end
  end
`else
  assign ex_fwd_a = 2'b00;
  assign ex_fwd_b = 2'b00;
`endif

  assign ex_ALUSrc    = idex_q.alu_src;
  assign ex_ALUOp     = idex_q.alu_op;
  assign ex_SetFlags  = idex_q.set_flags;
  assign ex_Branch    = idex_q.branch;
  assign ex_UncondB   = idex_q.uncond_b;
  assign ex_B         = idex_q.b_lt;
  assign mem_MemRead  = exmem_q.mem_read;
  assign mem_MemWrite = exmem_q.mem_write;
  assign wb_RegWrite  = memwb_q.reg_write;
  assign wb_MemtoReg  = memwb_q.mem_to_reg;
  assign wb_rd        = memwb_q.rd;

endmodule

// File: tb/tb_pipe_control.sv
// Scoreboard bench for pipe_control: each driven cycle queues hand-computed expected outputs,
// a negedge monitor pops and compares them field by field.
module tb_pipe_control;

  localparam int OpAddi = 1160;
  localparam int OpLsl  = 1691;
  localparam int OpLdur = 1986;
  localparam int OpStur = 1984;
  localparam int OpAdds = 1368;
  localparam int OpSubs = 1880;
  localparam int OpCbz  = 1440;
  localparam int OpMul  = 1240;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0;
  logic [10:0] instruct = '0;
  logic [4:0]  id_rn = '0;
  logic [4:0]  id_rm = '0;
  logic [4:0]  id_rd = '0;
  logic        br_taken = 1'b0;
  logic        stall;
  logic [2:0]  ex_ALUSrc;
  logic [1:0]  ex_ALUOp;
  logic        ex_SetFlags, ex_Branch, ex_UncondB, ex_B;
  logic [1:0]  ex_fwd_a, ex_fwd_b;
  logic        mem_MemRead, mem_MemWrite, wb_RegWrite, wb_MemtoReg;
  logic [4:0]  wb_rd;
  logic        id_illegal;

  pipe_control #(.REGW(5), .ZREG(31)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .instruct    (instruct),
    .id_rn       (id_rn),
    .id_rm       (id_rm),
    .id_rd       (id_rd),
    .br_taken    (br_taken),
    .stall       (stall),
    .ex_ALUSrc   (ex_ALUSrc),
    .ex_ALUOp    (ex_ALUOp),
    .ex_SetFlags (ex_SetFlags),
    .ex_Branch   (ex_Branch),
    .ex_UncondB  (ex_UncondB),
    .ex_B        (ex_B),
    .ex_fwd_a    (ex_fwd_a),
    .ex_fwd_b    (ex_fwd_b),
    .mem_MemRead (mem_MemRead),
    .mem_MemWrite(mem_MemWrite),
    .wb_RegWrite (wb_RegWrite),
    .wb_MemtoReg (wb_MemtoReg),
    .wb_rd       (wb_rd),
    .id_illegal  (id_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       stall;
    logic [2:0] alusrc;
    logic [1:0] aluop;
    logic       flags, br, unc, blt;
    logic [1:0] fa, fb;
    logic       mr, mw, rw, m2r;
    logic [4:0] wrd;
    logic       ill;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input string f, input logic [7:0] act,
                     input logic [7:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s %s: got %0d expected %0d", nm, f, act, want);
    end
  endtask

  // One cycle: drive the ID/branch inputs just after the edge, queue that cycle's expectation.
  // Expected order: stall alusrc aluop flags branch uncondb b fwd_a fwd_b
  //                 memread memwrite regwrite memtoreg wb_rd illegal
  task automatic step(input string nm, input bit rst, input bit v, input int op, input int rn,
                      input int rm, input int rd, input bit br,
                      input bit s, input int asrc, input int aop, input bit fl, input bit bra,
                      input bit unc, input bit blt, input int fa, input int fb, input bit mr,
                      input bit mw, input bit rw, input bit m2r, input int wrd, input bit ill);
    exp_t e;
    @(posedge clk);
    #1;
    reset    = rst;
    id_valid = v;
    instruct = 11'(op);
    id_rn    = 5'(rn);
    id_rm    = 5'(rm);
    id_rd    = 5'(rd);
    br_taken = br;
    e.name   = nm;
    e.stall  = s;
    e.alusrc = 3'(asrc);
    e.aluop  = 2'(aop);
    e.flags  = fl;
    e.br     = bra;
    e.unc    = unc;
    e.blt    = blt;
    e.fa     = 2'(fa);
    e.fb     = 2'(fb);
    e.mr     = mr;
    e.mw     = mw;
    e.rw     = rw;
    e.m2r    = m2r;
    e.wrd    = 5'(wrd);
    e.ill    = ill;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.name, "stall",        8'(stall),        8'(e.stall));
        chk(e.name, "ex_ALUSrc",    8'(ex_ALUSrc),    8'(e.alusrc));
        chk(e.name, "ex_ALUOp",     8'(ex_ALUOp),     8'(e.aluop));
        chk(e.name, "ex_SetFlags",  8'(ex_SetFlags),  8'(e.flags));
        chk(e.name, "ex_Branch",    8'(ex_Branch),    8'(e.br));
        chk(e.name, "ex_UncondB",   8'(ex_UncondB),   8'(e.unc));
        chk(e.name, "ex_B",         8'(ex_B),         8'(e.blt));
        chk(e.name, "ex_fwd_a",     8'(ex_fwd_a),     8'(e.fa));
        chk(e.name, "ex_fwd_b",     8'(ex_fwd_b),     8'(e.fb));
        chk(e.name, "mem_MemRead",  8'(mem_MemRead),  8'(e.mr));
        chk(e.name, "mem_MemWrite", 8'(mem_MemWrite), 8'(e.mw));
        chk(e.name, "wb_RegWrite",  8'(wb_RegWrite),  8'(e.rw));
        chk(e.name, "wb_MemtoReg",  8'(wb_MemtoReg),  8'(e.m2r));
        chk(e.name, "wb_rd",        8'(wb_rd),        8'(e.wrd));
        chk(e.name, "id_illegal",   8'(id_illegal),   8'(e.ill));
      end
    end
  end

  initial begin : driver
    int n;
    // Reset state, then async reset landing between edges with a full pipe.
    step("rst_state",   1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("a_addi_x1",   0, 1, OpAddi, 2, 0, 1, 0,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("a_lsl_x3",    0, 1, OpLsl, 4, 0, 3, 0,
                        0, 3'b010, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("a_async_rst", 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("a_addi_dec",  0, 1, OpAddi, 2, 0, 1, 0,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("a_addi_ex",   0, 0, 0, 0, 0, 0, 0,  0, 3'b010, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("a_addi_mem",  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("a_addi_wb",   0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    step("a_drain",     0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // LDUR X2,[X9] then ADDS X3,X2,X4: load-use.
    step("b_ldur",      0, 1, OpLdur, 9, 0, 2, 0,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("b_lu_stall",  0, 1, OpAdds, 2, 4, 3, 0,
                        1, 3'b100, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef PIPE_CONTROL_FWD_EN
    step("b_lu_go",     0, 1, OpAdds, 2, 4, 3, 0,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step("b_adds_ex",   0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b10, 1, 0, 0, 0, 2'b01, 0, 0, 0, 1, 1, 2, 0);
    step("b_adds_mem",  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("b_adds_wb",   0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0);
`else
    step("b_raw_stall", 0, 1, OpAdds, 2, 4, 3, 0,
                        1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step("b_go",        0, 1, OpAdds, 2, 4, 3, 0,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0);
    step("b_adds_ex",   0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("b_adds_mem",  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("b_adds_wb",   0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0);
`endif

    // ADDS X5,X6,X7 then SUBS X8,X5,X5: ALU-to-ALU dependency on both operands.
    step("c_adds",      0, 1, OpAdds, 6, 7, 5, 0,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef PIPE_CONTROL_FWD_EN
    step("c_subs_dec",  0, 1, OpSubs, 5, 5, 8, 0,
                        0, 0, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("c_subs_ex",   0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b10, 1, 0, 0, 0, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0);
    step("c_adds_wb",   0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5, 0);
    step("c_subs_wb",   0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8, 0);
    step("c_drain",     0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`else
    step("c_raw1",      0, 1, OpSubs, 5, 5, 8, 0,
                        1, 0, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("c_raw2",      0, 1, OpSubs, 5, 5, 8, 0,
                        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("c_go",        0, 1, OpSubs, 5, 5, 8, 0,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5, 0);
    step("c_subs_ex",   0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("c_subs_mem",  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("c_subs_wb",   0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8, 0);
`endif

    // CBZ X10 resolves taken in MEM while LDUR X2 / ADDS X3,X2 sit behind it.
    step("d_cbz",       0, 1, OpCbz, 0, 0, 10, 0,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("d_ldur",      0, 1, OpLdur, 9, 0, 2, 0,
                        0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("d_flush",     0, 1, OpAdds, 2, 4, 3, 1,
                        0, 3'b100, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("d_after",     0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("d_drain",     0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Illegal opcode 0, then ADDI X31 and a reader of X31.
    step("e_illegal",   0, 1, 0, 1, 2, 3, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("e_addi_x31",  0, 1, OpAddi, 1, 0, 31, 0,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("e_read_x31",  0, 1, OpAdds, 31, 31, 4, 0,
                        0, 3'b010, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("e_adds_ex",   0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("e_x31_wb",    0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("e_adds_wb",   0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4, 0);

    // Branch range edges, illegal 680, then MUL and STUR through the pipe.
    step("f_b160",      0, 1, 160, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("f_b191",      0, 1, 191, 0, 0, 0, 0,  0, 3'b001, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("f_blt679",    0, 1, 679, 0, 0, 0, 0,  0, 3'b001, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("f_op680",     0, 1, 680, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    step("f_mul",       0, 1, OpMul, 1, 2, 6, 0,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("f_stur",      0, 1, OpStur, 1, 0, 7, 0,
                        0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("f_stur_ex",   0, 0, 0, 0, 0, 0, 0,  0, 3'b100, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("f_stur_mem",  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 6, 0);
    step("f_stur_wb",   0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    #2;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
